an_decoder: RTL and testbench
=============================

# an_decoder

Single-error-correcting AN-code decoder for A = 29, data width 23 bits. Each input codeword is 29·N with at most one arithmetic error of ±2^k. The block computes the residue mod 29, identifies and removes the error, and returns N by exact division by 29. It sits on the receive side of the AN-protected datapath, is fully pipelined, and accepts one word per clock.

## Interface
- A, default 29: code constant; 2 is a primitive root mod 29, so 2^k mod 29 for k = 0..27 covers residues 1..28 once each.
- IN_W, default 28: codeword width.
- OUT_W, default 23: decoded data width; 29·(2^23−1) < 2^28.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  ANe is valid this cycle.
- ANe  in  28  received codeword, possibly erroneous.
- out_valid  out  1  Nc, err_det and ovf are valid this cycle.
- Nc  out  23  decoded data N.
- err_det  out  1  residue was nonzero; a correction was applied.
- ovf  out  1  the corrected value fell outside 0..29·(2^23−1); Nc is not meaningful.

## Operation
- Residue:
  - R = ANe mod 29.
  - Computed as a sum of per-bit constants (2^i mod 29) for each set bit, then reduced mod 29.
  - No divider.
- R = 0: C = ANe, err_det = 0.
- R ≠ 0:
  - Let k be the unique index in 0..27 with 2^k mod 29 = R, taken from a 28-entry syndrome table.
  - Let j = (k+14) mod 28. Since 2^14 ≡ −1 (mod 29), the error +2^k and the error −2^j give the same residue.
  - Disambiguation is fixed:
    - If ANe[k] = 1: C = ANe − 2^k.
    - Otherwise: C = ANe + 2^j.
  - err_det = 1.
- C is computed in 29 bits.
  - ovf = 1 if C < 0 (a borrow) or C > 243,269,603, which is 29·(2^23−1).
  - Otherwise ovf = 0.
- Division:
  - Nc = (C[22:0] · inv29) mod 2^23.
  - inv29 is the multiplicative inverse of 29 mod 2^23. This gives the exact result because C is a multiple of 29.
  - If ovf = 1, Nc is still driven by this formula but is not meaningful.
- Two or more bit errors are not detected. The output is whatever the rules above produce.

## Timing
- Latency is 2 cycles.
  - A word sampled with in_valid = 1 at edge t appears on the outputs after edge t+2, with out_valid = 1.
- Throughput is one word per cycle. There is no backpressure and no stall.
- Stage 1 registers: ANe, R, in_valid.
- Stage 2 registers: Nc, err_det, ovf, out_valid.
- Bubbles (in_valid = 0) propagate as out_valid = 0. Data registers may hold stale values during a bubble.
- Reset:
  - When rst = 1 at an edge, all pipeline registers clear: out_valid = 0, Nc = 0, err_det = 0, ovf = 0.
  - Any words in flight mid-operation are discarded.
  - A word presented in the same cycle as rst is dropped.
  - The first word accepted after reset deasserts appears 2 cycles later.

## Structure
- Shared package an_code_pkg holds:
  - A, IN_W, OUT_W.
  - INV29_23 = inverse of 29 mod 2^23.
  - MAXCW = 243,269,603.
  - The 28-entry constant array POW2_MOD29[i] = 2^i mod 29.
  - The inverse syndrome function residue → k.
- One sub-module, an_residue_mod29: combinational 28-bit → 5-bit residue, instantiated in stage 1.
- Correction, range check and inverse multiply live in the top-level an_decoder, stage 2.

## Test plan
- No error: ANe = 38048 (29·1312) → Nc = 1312, err_det = 0, ovf = 0, two cycles later.
- Positive single-bit errors: ANe = 38049, 38050, 38052, 38056, 38064, 38112, 38304, 38560, 40096, 46240, 54432, 103584, 169120, 300192, 562336, 1086624, 2135200, 4232352, 8426656, 16815264, 33592480, 67146912, 134255776 → each gives Nc = 1312, err_det = 1.
  - These are +2^k for k = 0–4, 6, 8, 9, 11, 13, 14 and 16–27.
- Negative single-bit errors: ANe = 38016 (R = 26), 37920 (R = 17), 37024 (R = 20), 33952 (R = 22), 5280 (R = 2) → Nc = 1312, err_det = 1, via the add-2^j path.
- Boundaries:
  - ANe = 0 → Nc = 0, err_det = 0.
  - ANe = 243,269,603 → Nc = 8,388,607.
  - ANe = 1 → C = 0, Nc = 0, err_det = 1.
  - ANe = 268,435,455 → ovf = 1.
- Pipeline:
  - Back-to-back words with bubbles in between → in-order outputs; out_valid mirrors in_valid delayed by 2 cycles.
  - rst asserted with 2 words in flight → both are dropped; outputs read 0 on the next cycle.

Source files
------------

// File: rtl/an_code_pkg.sv
// an_code_pkg: AN-code (A=29) constants, residue table and syndrome lookup shared by the decoder
package an_code_pkg;
  localparam int A = 29;
  localparam int IN_W = 28;
  localparam int OUT_W = 23;
  localparam logic [28:0] MAXCW = 29'd243269603;
  function automatic logic [OUT_W-1:0] inv_mod_pow2(input logic [63:0] a);
    logic [63:0] x;
    x = a;
    for (int i = 0; i < 5; i++) x = x * (64'd2 - a * x);
    return x[OUT_W-1:0];
  endfunction
  localparam logic [OUT_W-1:0] INV29_23 = inv_mod_pow2(64'(A));
  localparam logic [4:0] POW2_MOD29 [IN_W] = '{
    5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd3, 5'd6, 5'd12, 5'd24, 5'd19,
    5'd9, 5'd18, 5'd7, 5'd14, 5'd28, 5'd27, 5'd25, 5'd21, 5'd13, 5'd26,
    5'd23, 5'd17, 5'd5, 5'd10, 5'd20, 5'd11, 5'd22, 5'd15};
  function automatic logic [4:0] syn_k(input logic [4:0] r);
    syn_k = '0;
    for (int i = 0; i < IN_W; i++) if (POW2_MOD29[i] == r) syn_k = 5'(i);
  endfunction
endpackage

// File: rtl/an_decoder_if.sv
// an_decoder_if: codeword in (in_valid, ANe) and decoded result out (out_valid, Nc, err_det, ovf)
interface an_decoder_if;
  import an_code_pkg::*;
  logic in_valid;
  logic [IN_W-1:0] ANe;
  logic out_valid;
  logic [OUT_W-1:0] Nc;
  logic err_det;
  logic ovf;
  modport master (output in_valid, ANe, input out_valid, Nc, err_det, ovf);
  modport slave (input in_valid, ANe, output out_valid, Nc, err_det, ovf);
endinterface

// File: rtl/an_residue_mod29.sv
// an_residue_mod29: combinational x_i mod 29 (x_i: 28-bit word in, r_o: 5-bit residue out), folds 2^5 = 3 mod 29
module an_residue_mod29 import an_code_pkg::*; (
  input  logic [IN_W-1:0] x_i,
  output logic [4:0]      r_o
);
  logic [9:0] s;
  logic [6:0] f1;
  logic [5:0] f2;
  always_comb begin
    s = '0;
    for (int i = 0; i < IN_W; i++) s = s + (x_i[i] ? 10'(POW2_MOD29[i]) : 10'd0);
    f1 = 7'(s[9:5]) * 7'd3 + 7'(s[4:0]);
    f2 = 6'(f1[6:5]) * 6'd3 + 6'(f1[4:0]);
    r_o = f2 >= 6'd29 ? 5'(f2 - 6'd29) : f2[4:0];
  end
endmodule

// File: rtl/an_decoder.sv
// an_decoder: 2-stage SEC AN-code (A=29) decoder (clk, rst, bus: in_valid/ANe in, out_valid/Nc/err_det/ovf out)
module an_decoder import an_code_pkg::*; (
  input logic        clk,
  input logic        rst,
  an_decoder_if.slave bus
);
  logic [IN_W-1:0] ane_q;
  logic [4:0] r_d, r_q, k, j;
  logic v1_q, v2_q;
  logic [28:0] base, c;
  logic [OUT_W-1:0] nc_d, nc_q;
  logic err_d, err_q, ovf_d, ovf_q;
  an_residue_mod29 u_res (.x_i(bus.ANe), .r_o(r_d));
  always_comb begin
    k = syn_k(r_q);
    j = k >= 5'd14 ? k - 5'd14 : k + 5'd14;
    base = {1'b0, ane_q};
    c = r_q == 5'd0 ? base : ane_q[k] ? base - (29'd1 << k) : base + (29'd1 << j);
    err_d = r_q != 5'd0;
    ovf_d = c > MAXCW;
    nc_d = c[OUT_W-1:0] * INV29_23;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      ane_q <= '0;
      r_q <= '0;
      v2_q <= 1'b0;
      nc_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      v1_q <= bus.in_valid;
      ane_q <= bus.ANe;
      r_q <= r_d;
      v2_q <= v1_q;
      nc_q <= nc_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.out_valid = v2_q;
  assign bus.Nc = nc_q;
  assign bus.err_det = err_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_an_decoder.sv
// tb_an_decoder: table-driven check of an_decoder plus reset-in-flight sequence
module tb_an_decoder;
  import an_code_pkg::*;
  typedef struct {
    logic v;
    logic [27:0] ane;
    logic [22:0] nc;
    logic err;
    logic ovf;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  an_decoder_if bus ();
  an_decoder dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  vec_t tbl[$];
  vec_t p1, p2;
  function automatic vec_t mk(logic v, logic [27:0] ane, logic [22:0] nc, logic err, logic ovf);
    vec_t r;
    r.v = v;
    r.ane = ane;
    r.nc = nc;
    r.err = err;
    r.ovf = ovf;
    return r;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_out(vec_t e, int idx);
    chk($sformatf("out_valid[%0d]", idx), 32'(bus.out_valid), 32'(e.v));
    if (e.v) begin
      chk($sformatf("err_det[%0d] ANe=%0d", idx, e.ane), 32'(bus.err_det), 32'(e.err));
      chk($sformatf("ovf[%0d] ANe=%0d", idx, e.ane), 32'(bus.ovf), 32'(e.ovf));
      if (!e.ovf) chk($sformatf("Nc[%0d] ANe=%0d", idx, e.ane), 32'(bus.Nc), 32'(e.nc));
    end
  endtask
  task automatic chk_zero(string tag);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " Nc"}, 32'(bus.Nc), 32'd0);
    chk({tag, " err_det"}, 32'(bus.err_det), 32'd0);
    chk({tag, " ovf"}, 32'(bus.ovf), 32'd0);
  endtask
  task automatic step(vec_t d, int idx);
    @(negedge clk);
    chk_out(p2, idx - 2);
    bus.in_valid = d.v;
    bus.ANe = d.ane;
    p2 = p1;
    p1 = d;
  endtask
  initial begin
    int pos [23] = '{38049, 38050, 38052, 38056, 38064, 38112, 38304, 38560, 40096, 46240,
                     54432, 103584, 169120, 300192, 562336, 1086624, 2135200, 4232352,
                     8426656, 16815264, 33592480, 67146912, 134255776};
    int neg [5] = '{38016, 37920, 37024, 33952, 5280};
    bus.in_valid = 1'b0;
    bus.ANe = '0;
    p1 = mk(0, 0, 0, 0, 0);
    p2 = p1;
    tbl.push_back(mk(1, 28'd38048, 23'd1312, 0, 0));
    foreach (pos[i]) tbl.push_back(mk(1, 28'(pos[i]), 23'd1312, 1, 0));
    tbl.push_back(mk(0, 28'd0, 23'd0, 0, 0));
    foreach (neg[i]) begin
      tbl.push_back(mk(1, 28'(neg[i]), 23'd1312, 1, 0));
      if (i % 2 == 0) tbl.push_back(mk(0, 28'd77, 23'd0, 0, 0));
    end
    tbl.push_back(mk(1, 28'd0, 23'd0, 0, 0));
    tbl.push_back(mk(1, 28'd243269603, 23'd8388607, 0, 0));
    tbl.push_back(mk(0, 28'd0, 23'd0, 0, 0));
    tbl.push_back(mk(0, 28'd0, 23'd0, 0, 0));
    tbl.push_back(mk(1, 28'd1, 23'd0, 1, 0));
    tbl.push_back(mk(1, 28'd268435455, 23'd0, 0, 1));
    tbl.push_back(mk(1, 28'd243269632, 23'd0, 0, 1));
    tbl.push_back(mk(1, 28'd145, 23'd5, 0, 0));
    tbl.push_back(mk(1, 28'd2900000, 23'd100000, 0, 0));
    tbl.push_back(mk(0, 28'd0, 23'd0, 0, 0));
    tbl.push_back(mk(0, 28'd0, 23'd0, 0, 0));
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    foreach (tbl[i]) step(tbl[i], i);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ANe = 28'd38049;
    @(negedge clk);
    bus.ANe = 28'd5280;
    @(negedge clk);
    chk("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
    chk("pre-reset Nc", 32'(bus.Nc), 32'd1312);
    chk("pre-reset err_det", 32'(bus.err_det), 32'd1);
    rst = 1'b1;
    bus.ANe = 28'd145;
    @(negedge clk);
    chk_zero("flush");
    rst = 1'b0;
    bus.ANe = 28'd2900000;
    @(negedge clk);
    chk("dropped B out_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post-reset out_valid", 32'(bus.out_valid), 32'd1);
    chk("post-reset Nc", 32'(bus.Nc), 32'd100000);
    chk("post-reset err_det", 32'(bus.err_det), 32'd0);
    @(negedge clk);
    chk("post-reset bubble", 32'(bus.out_valid), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
